// File: rtl/dcache_wb_if.sv
// Core data-memory port plus word-serial burst port of the data cache.
// slave = cache side, master = core/memory side.
interface dcache_wb_if;
  logic        req_rd;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  req_rd, req_we, req_addr, req_wdata,
    input  mem_rdata, mem_ack,
    output rd_data, miss,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_rd, req_we, req_addr, req_wdata,
    output mem_rdata, mem_ack,
    input  rd_data, miss,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache for the MEM/WB stage.
// Misses write back a dirty victim, fill word-serially, then retry-hit.
module dcache_wb #(
  parameter int SET_BITS        = 4,
  parameter int LINE_WORDS_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  dcache_wb_if.slave  bus,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int LW    = LINE_WORDS_LOG2;
  localparam int OFF   = LW + 2;
  localparam int LINES = 1 << SET_BITS;
  localparam int WORDS = 1 << LW;
  localparam int TAG_W = 32 - OFF - SET_BITS;

  typedef enum logic [1:0] {
    IDLE, WBACK, FILL
  } state_t;

  state_t state;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags [LINES];
  logic [31:0]      data [LINES*WORDS];

  logic [31-OFF:0]  missLine;
  logic [TAG_W-1:0] vicTag;
  logic [LW-1:0]    beat;
  logic             retry;

  logic [SET_BITS-1:0] idx;
  logic [LW-1:0]       word;
  logic [TAG_W-1:0]    tag;
  logic [SET_BITS-1:0] missIdx;
  logic [TAG_W-1:0]    missTag;
  logic [LW-1:0]       beatNext;
  logic isStore, active, hit;
  logic lastBeat, ack;
  logic unusedAddrLsb;

  assign idx      = bus.req_addr[SET_BITS+OFF-1:OFF];
  assign word     = bus.req_addr[OFF-1:2];
  assign tag      = bus.req_addr[31:SET_BITS+OFF];
  assign missIdx  = missLine[SET_BITS-1:0];
  assign missTag  = missLine[31-OFF:SET_BITS];
  assign beatNext = beat + 1'b1;
  assign lastBeat = &beat;
  assign ack      = bus.mem_req & bus.mem_ack;

  assign isStore = |bus.req_we;
  assign active  = bus.req_rd | isStore;
  assign hit     = valid[idx] && (tags[idx] == tag);

  assign bus.miss = (state != IDLE) |
                    (active & ~hit);

  assign unusedAddrLsb = ^bus.req_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      bus.rd_data   <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      missLine      <= '0;
      vicTag        <= '0;
      beat          <= '0;
      retry         <= 1'b0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          retry <= 1'b0;
          if (active && hit) begin
            if (isStore) dirty[idx] <= 1'b1;
            else bus.rd_data <= data[{idx, word}];
            if (!retry) hit_cnt <= hit_cnt + 32'd1;
          end else if (active) begin
            missLine    <= bus.req_addr[31:OFF];
            vicTag      <= tags[idx];
            miss_cnt    <= miss_cnt + 32'd1;
            beat        <= '0;
            bus.mem_req <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              state         <= WBACK;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= {tags[idx], idx,
                                {LW{1'b0}}, 2'b00};
              bus.mem_wdata <= data[{idx, {LW{1'b0}}}];
            end else begin
              state        <= FILL;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= {tag, idx,
                               {LW{1'b0}}, 2'b00};
            end
          end
        end
        WBACK: begin
          if (ack) begin
            beat <= beatNext;
            if (lastBeat) begin
              state        <= FILL;
              bus.mem_we   <= 1'b0;
              bus.mem_addr <= {missLine,
                               {LW{1'b0}}, 2'b00};
            end else begin
              bus.mem_addr  <= {vicTag, missIdx,
                                beatNext, 2'b00};
              bus.mem_wdata <= data[{missIdx, beatNext}];
            end
          end
        end
        FILL: begin
          if (ack) begin
            beat         <= beatNext;
            bus.mem_addr <= {missLine, beatNext, 2'b00};
            if (lastBeat) begin
              state          <= IDLE;
              bus.mem_req    <= 1'b0;
              valid[missIdx] <= 1'b1;
              dirty[missIdx] <= 1'b0;
              retry          <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Arrays carry no reset; valid gates every use of their contents.
  always_ff @(posedge clk) begin
    if (state == FILL && ack) begin
      data[{missIdx, beat}] <= bus.mem_rdata;
      if (lastBeat) tags[missIdx] <= missTag;
    end else if (state == IDLE && active &&
                 hit && isStore) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.req_we[b])
          data[{idx, word}][8*b +: 8] <=
            bus.req_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dcache_wb.sv
// Self-checking bench for dcache_wb: vector table, scoreboard and
// a behavioural burst memory with configurable ack latency.
module tb_dcache_wb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] hitCnt, missCnt;

  dcache_wb_if bus();

  dcache_wb dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hitCnt),
    .miss_cnt (missCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wd;
    int          nMiss;
    logic [31:0] expRd;
    int          nWb;
    logic [31:0] wbBase;
    int          nFill;
    logic [31:0] fillBase;
    int          expHit;
    int          expMc;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  int checks = 0;
  int errors = 0;
  int ackDelay = 0;
  int waitCnt = 0;
  logic [31:0] beatAddr;
  beat_t beatLog[$];
  logic [31:0] sbQ[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  vec_t tbl [11];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  function automatic logic [31:0] memRd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] shRd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory responder: decides the ack for the coming rising edge.
  always @(negedge clk) begin
    if (rst || bus.mem_req !== 1'b1) begin
      bus.mem_ack = 1'b0;
      waitCnt = 0;
    end else begin
      if (waitCnt == 0) beatAddr = bus.mem_addr;
      else check("addrStable", bus.mem_addr, beatAddr);
      if (waitCnt >= ackDelay) begin
        bus.mem_ack = 1'b1;
        beatLog.push_back('{bus.mem_we, bus.mem_addr,
                            bus.mem_wdata});
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        else bus.mem_rdata = memRd(bus.mem_addr);
        waitCnt = 0;
      end else begin
        bus.mem_ack = 1'b0;
        waitCnt++;
      end
    end
  end

  task automatic access(input vec_t v);
    int n = 0;
    logic [31:0] exp;
    logic [31:0] a;
    logic [31:0] w;
    beatLog.delete();
    bus.req_rd    = v.rd;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wd;
    #1;
    while (bus.miss === 1'b1 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("missCycles", n, v.nMiss);
    sbQ.push_back(v.expRd);
    @(negedge clk);
    bus.req_rd = 1'b0;
    bus.req_we = 4'h0;
    #1;
    exp = sbQ.pop_front();
    check("rd_data", bus.rd_data, exp);
    check("beatCount", beatLog.size(), v.nWb + v.nFill);
    foreach (beatLog[i]) begin
      if (i < v.nWb) begin
        a = v.wbBase + 4 * i;
        check("wbWe", {31'h0, beatLog[i].we}, 32'd1);
        check("wbAddr", beatLog[i].addr, a);
        check("wbData", beatLog[i].data, shRd(a));
      end else begin
        a = v.fillBase + 4 * (i - v.nWb);
        check("fillWe", {31'h0, beatLog[i].we}, 32'd0);
        check("fillAddr", beatLog[i].addr, a);
      end
    end
    if (v.we != 4'h0) begin
      a = {v.addr[31:2], 2'b00};
      w = shRd(a);
      for (int b = 0; b < 4; b++)
        if (v.we[b]) w[8*b +: 8] = v.wd[8*b +: 8];
      shadow[a] = w;
    end
    if (v.expHit >= 0) begin
      check("hit_cnt", hitCnt, v.expHit);
      check("miss_cnt", missCnt, v.expMc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    bus.req_rd    = 1'b0;
    bus.req_we    = 4'h0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    mem[32'h10]    = 32'hDEADBEEF;
    shadow[32'h10] = 32'hDEADBEEF;

    tbl[0]  = '{1, 4'h0, 32'h010, 32'h0, 5, 32'hDEADBEEF,
                0, 32'h0, 4, 32'h010, 0, 1};
    tbl[1]  = '{0, 4'h3, 32'h014, 32'h11223344, 0,
                32'hDEADBEEF, 0, 32'h0, 0, 32'h0, 1, 1};
    tbl[2]  = '{1, 4'h0, 32'h014, 32'h0, 0, 32'hC0DE3344,
                0, 32'h0, 0, 32'h0, 2, 1};
    tbl[3]  = '{1, 4'h0, 32'h410, 32'h0, 9, 32'hC0DE0410,
                4, 32'h010, 4, 32'h410, 2, 2};
    tbl[4]  = '{0, 4'h8, 32'h020, 32'hAB000000, 5,
                32'hC0DE0410, 0, 32'h0, 4, 32'h020, 2, 3};
    tbl[5]  = '{1, 4'h0, 32'h420, 32'h0, 9, 32'hC0DE0420,
                4, 32'h020, 4, 32'h420, 2, 4};
    tbl[6]  = '{1, 4'h0, 32'h014, 32'h0, 5, 32'hC0DE3344,
                0, 32'h0, 4, 32'h010, 2, 5};
    tbl[7]  = '{1, 4'h0, 32'h424, 32'h0, 0, 32'hC0DE0424,
                0, 32'h0, 0, 32'h0, 3, 5};
    tbl[8]  = '{1, 4'h0, 32'h020, 32'h0, 5, 32'hABDE0020,
                0, 32'h0, 4, 32'h020, 3, 6};
    tbl[9]  = '{1, 4'h1, 32'h024, 32'h000000EE, 0,
                32'hABDE0020, 0, 32'h0, 0, 32'h0, 4, 6};
    tbl[10] = '{1, 4'h0, 32'h024, 32'h0, 0, 32'hC0DE00EE,
                0, 32'h0, 0, 32'h0, 5, 6};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstRdData", bus.rd_data, 32'h0);
    check("rstMemReq", {31'h0, bus.mem_req}, 32'h0);
    check("rstMemWe", {31'h0, bus.mem_we}, 32'h0);
    check("rstMemAddr", bus.mem_addr, 32'h0);
    check("rstMemWdata", bus.mem_wdata, 32'h0);
    check("rstHits", hitCnt, 32'h0);
    check("rstMisses", missCnt, 32'h0);
    check("idleMiss", {31'h0, bus.miss}, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) access(tbl[i]);

    // Each beat held for 3 extra cycles before its ack.
    ackDelay = 3;
    v = '{1, 4'h0, 32'h030, 32'h0, 17, 32'hC0DE0030,
          0, 32'h0, 4, 32'h030, -1, 0};
    access(v);
    ackDelay = 0;

    beatLog.delete();
    bus.req_rd   = 1'b1;
    bus.req_addr = 32'h040;
    n = 0;
    while (beatLog.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rstWaitBeats", beatLog.size(), 32'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rstMidReq", {31'h0, bus.mem_req}, 32'h0);
    check("rstMidHits", hitCnt, 32'h0);
    check("rstMidMisses", missCnt, 32'h0);
    check("rstMidRd", bus.rd_data, 32'h0);
    @(negedge clk);
    bus.req_rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    v = '{1, 4'h0, 32'h010, 32'h0, 5, 32'hDEADBEEF,
          0, 32'h0, 4, 32'h010, 0, 1};
    access(v);
    v = '{1, 4'h0, 32'h040, 32'h0, 5, 32'hC0DE0040,
          0, 32'h0, 4, 32'h040, 0, 2};
    access(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
